// File: rtl/puf_pkg.sv
// Shared definitions for the ring-oscillator PUF evaluation controller.
// Holds the FSM state encoding and the default parameter values.
// Pure definitions: no latency, no backpressure.
package puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_COUNT   = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } puf_state_t;

  localparam int unsigned PUF_N_RO   = 32;
  localparam int unsigned PUF_N_BITS = 8;
  localparam int unsigned PUF_SETTLE = 16;
  localparam int unsigned PUF_WINDOW = 1024;
  localparam int unsigned PUF_CNT_W  = 16;

  function automatic int unsigned puf_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/puf_edge_sync.sv
// 2-flop synchronizer plus rising-edge detector for one raw oscillator output.
// Latency: an input rise shows up on o_rise after 2 edges, so it lands in a counter on the 3rd.
// No backpressure: o_rise is a single-cycle pulse that is simply dropped if unused.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   i_ro       : raw oscillator output, asynchronous to clk
//   o_rise     : one-cycle pulse per synchronized rising edge
module puf_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ro,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_ro;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/puf_eval_ctrl.sv
// RO-PUF evaluation controller: per response bit, settle, count two oscillators, compare.
// Latency: done pulses N_BITS*(SETTLE+WINDOW+1)+1 cycles after the start-accepting edge (cycle 1 = first cycle after it).
// Backpressure: none; start is only sampled in IDLE and ignored otherwise.
//
// Ports:
//   clk, rst_n       : clock and asynchronous active-low reset
//   start, challenge : evaluation request and base oscillator index (latched on accept)
//   ro_a, ro_b       : raw outputs of the selected oscillators (asynchronous)
//   ro_en, sel_a/b   : oscillator enable and selects
//   busy, done       : not-IDLE flag and one-cycle completion pulse
//   valid, response  : completed response word, held until the next accepted start
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned N_RO   = PUF_N_RO,
  parameter int unsigned N_BITS = PUF_N_BITS,
  parameter int unsigned SETTLE = PUF_SETTLE,
  parameter int unsigned WINDOW = PUF_WINDOW,
  parameter int unsigned CNT_W  = PUF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [$clog2(N_RO)-1:0] challenge,
  input  logic                    ro_a,
  input  logic                    ro_b,
  output logic                    ro_en,
  output logic [$clog2(N_RO)-1:0] sel_a,
  output logic [$clog2(N_RO)-1:0] sel_b,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  output logic [N_BITS-1:0]       response
);

  localparam int unsigned SEL_W   = $clog2(N_RO);
  localparam int unsigned IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  // One shared phase timer covers both the settle and the count window.
  localparam int unsigned TMR_MAX = puf_max(SETTLE, WINDOW);
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_BITS - 1);
  localparam logic [SEL_W-1:0] HALF        = SEL_W'(N_RO / 2);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  puf_state_t         r_state;
  puf_state_t         w_next;
  logic [TMR_W-1:0]   r_tmr;
  logic [IDX_W-1:0]   r_idx;
  logic [SEL_W-1:0]   r_base;
  logic [CNT_W-1:0]   r_cnt_a;
  logic [CNT_W-1:0]   r_cnt_b;
  logic               r_valid;
  logic [N_BITS-1:0]  r_resp;

  logic               w_rise_a;
  logic               w_rise_b;
  logic               w_ro_en;
  logic               w_busy;
  logic               w_done;
  logic [SEL_W-1:0]   w_sel_a;
  logic [SEL_W-1:0]   w_sel_b;

  puf_edge_sync u_sync_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ro   (ro_a),
    .o_rise (w_rise_a)
  );

  puf_edge_sync u_sync_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ro   (ro_b),
    .o_rise (w_rise_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ro_en = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        w_ro_en = 1'b1;
        if (r_tmr == SETTLE_LAST) w_next = S_COUNT;
      end
      S_COUNT: begin
        w_ro_en = 1'b1;
        if (r_tmr == WINDOW_LAST) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        w_ro_en = 1'b1;
        w_next  = (r_idx == IDX_LAST) ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // Selects are parked at 0 whenever the oscillators are disabled; N_RO is a
  // power of two, so the SEL_W-bit truncation is the modulo wrap.
  assign w_sel_a = w_ro_en ? (r_base + SEL_W'(r_idx))        : '0;
  assign w_sel_b = w_ro_en ? (r_base + SEL_W'(r_idx) + HALF) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr   <= '0;
      r_idx   <= '0;
      r_base  <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_valid <= 1'b0;
      r_resp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= challenge;
            r_idx   <= '0;
            r_tmr   <= '0;
            r_valid <= 1'b0;
            r_resp  <= '0;
          end
        end
        S_SETTLE: begin
          r_cnt_a <= '0;
          r_cnt_b <= '0;
          r_tmr   <= (r_tmr == SETTLE_LAST) ? '0 : r_tmr + TMR_W'(1);
        end
        S_COUNT: begin
          r_tmr <= (r_tmr == WINDOW_LAST) ? '0 : r_tmr + TMR_W'(1);
          // Saturate rather than wrap so a fast oscillator can never lose the compare.
          if (w_rise_a && (r_cnt_a != CNT_MAX)) r_cnt_a <= r_cnt_a + CNT_W'(1);
          if (w_rise_b && (r_cnt_b != CNT_MAX)) r_cnt_b <= r_cnt_b + CNT_W'(1);
        end
        S_COMPARE: begin
          // Strict greater-than: a tie resolves to 0.
          r_resp[r_idx] <= (r_cnt_a > r_cnt_b);
          r_cnt_a       <= '0;
          r_cnt_b       <= '0;
          r_tmr         <= '0;
          // valid rises together with the last bit so it is already set in DONE.
          if (r_idx == IDX_LAST) r_valid <= 1'b1;
          else                   r_idx   <= r_idx + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign ro_en    = w_ro_en;
  assign sel_a    = w_sel_a;
  assign sel_b    = w_sel_b;
  assign busy     = w_busy;
  assign done     = w_done;
  assign valid    = r_valid;
  assign response = r_resp;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
module tb_puf_eval_ctrl;

  localparam int N_RO   = 32;
  localparam int N_BITS = 8;
  localparam int SETTLE = 4;
  localparam int WINDOW = 64;
  localparam int CNT_W  = 16;
  localparam int BITLEN = SETTLE + WINDOW + 1;   // 69
  localparam int LAT    = N_BITS * BITLEN + 1;   // 553

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [4:0] challenge;
  logic       ro_a, ro_b;
  logic       ro_en, busy, done, valid;
  logic [4:0] sel_a, sel_b;
  logic [7:0] response;

  logic       start2;
  logic [2:0] challenge2;
  logic       ro_a2, ro_b2;
  logic       ro_en2, busy2, done2, valid2;
  logic [2:0] sel_a2, sel_b2;
  logic [3:0] response2;

  puf_eval_ctrl #(
    .N_RO(N_RO), .N_BITS(N_BITS), .SETTLE(SETTLE), .WINDOW(WINDOW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en), .sel_a(sel_a), .sel_b(sel_b),
    .busy(busy), .done(done), .valid(valid), .response(response)
  );

  // Narrow-counter instance: a period-4 oscillator overflows a 4-bit counter in one window.
  puf_eval_ctrl #(
    .N_RO(8), .N_BITS(4), .SETTLE(SETTLE), .WINDOW(WINDOW), .CNT_W(4)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .challenge(challenge2),
    .ro_a(ro_a2), .ro_b(ro_b2), .ro_en(ro_en2), .sel_a(sel_a2), .sel_b(sel_b2),
    .busy(busy2), .done(done2), .valid(valid2), .response(response2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Oscillator stimulus. mode 0: A period 6, B period 10. mode 1: A and B identical.
  // mode 2: A period 10, B period 6.
  int mode = 0;
  int ph   = 0;
  initial begin
    ro_a = 0; ro_b = 0; ro_a2 = 0; ro_b2 = 0;
    forever begin
      @(negedge clk);
      ph++;
      case (mode)
        0:       begin ro_a = (ph % 6) < 3;  ro_b = (ph % 10) < 5; end
        1:       begin ro_a = (ph % 6) < 3;  ro_b = ro_a;          end
        default: begin ro_a = (ph % 10) < 5; ro_b = (ph % 6) < 3;  end
      endcase
      ro_a2 = (ph % 4) < 2;
      ro_b2 = (ph % 8) < 4;
    end
  end

  typedef struct packed {
    logic [31:0] exp_cyc;
    logic [7:0]  resp;
    logic [4:0]  chal;
  } exp_t;

  exp_t       sb_q[$];
  logic [4:0] obs_a[$];
  logic [4:0] obs_b[$];

  // Monitor: collects the select pair of every bit, and on each done pulse pops
  // the expected record and compares.
  initial begin
    exp_t       e;
    logic       prev_en;
    logic [4:0] pa, pb;
    prev_en = 1'b0; pa = '0; pb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        obs_a.delete(); obs_b.delete(); prev_en = 1'b0;
      end else begin
        if (ro_en) begin
          if ($isunknown({sel_a, sel_b})) fail_now("sel_unknown");
          if (!prev_en || sel_a != pa || sel_b != pb) begin
            obs_a.push_back(sel_a);
            obs_b.push_back(sel_b);
          end
          pa = sel_a; pb = sel_b;
        end
        prev_en = ro_en;
        if (done) begin
          if (sb_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            e = sb_q.pop_front();
            check("done_cycle", cyc, e.exp_cyc);
            check("response", {24'd0, response}, {24'd0, e.resp});
            check("valid_at_done", {31'd0, valid}, 32'd1);
            check("busy_at_done", {31'd0, busy}, 32'd1);
            check("n_sel_pairs", obs_a.size(), N_BITS);
            for (int i = 0; i < N_BITS && i < obs_a.size(); i++) begin
              check("sel_a", {27'd0, obs_a[i]}, (e.chal + i) % N_RO);
              check("sel_b", {27'd0, obs_b[i]}, (e.chal + i + N_RO / 2) % N_RO);
            end
          end
          obs_a.delete(); obs_b.delete();
        end
      end
    end
  end

  // Accepting edge is the next posedge; cyc equals acc right after it. Counting the
  // cycle that follows that edge as cycle 1, done must be seen in cycle LAT.
  task automatic issue(input logic [4:0] chal, input logic [7:0] resp, output int acc);
    exp_t e;
    @(negedge clk);
    challenge = chal;
    start     = 1'b1;
    acc       = cyc + 1;
    e.exp_cyc = acc + LAT - 1;
    e.resp    = resp;
    e.chal    = chal;
    sb_q.push_back(e);
    @(negedge clk);
    start     = 1'b0;
    challenge = ~chal;  // must not disturb the latched base
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < LAT + 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now(name);
  endtask

  task automatic check_hold(input logic [7:0] resp);
    repeat (5) @(negedge clk);
    check("valid_hold", {31'd0, valid}, 32'd1);
    check("response_hold", {24'd0, response}, {24'd0, resp});
    check("idle_ro_en", {31'd0, ro_en}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog (cycle %0d)", cyc);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog expired");
  end

  int acc;
  int offs[4] = '{5, 70, 300, 552};

  initial begin
    rst_n = 1'b0; start = 1'b0; challenge = '0;
    start2 = 1'b0; challenge2 = '0;
    repeat (2) @(negedge clk);
    check("rst_ro_en", {31'd0, ro_en}, 32'd0);
    check("rst_sel_a", {27'd0, sel_a}, 32'd0);
    check("rst_sel_b", {27'd0, sel_b}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_response", {24'd0, response}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A faster than B, challenge 5: selects 5/21 .. 12/28, all ones.
    mode = 0;
    issue(5'd5, 8'hFF, acc);
    wait_idle("timeout_basic");
    check_hold(8'hFF);

    // Wrap: challenge 30 gives 30,31,0..5 / 14..21; B faster so all zeros.
    mode = 2;
    issue(5'd30, 8'h00, acc);
    wait_idle("timeout_wrap");
    check_hold(8'h00);

    // Identical oscillators tie on every bit.
    mode = 1;
    issue(5'd17, 8'h00, acc);
    wait_idle("timeout_tie");
    check_hold(8'h00);

    // start pulses while busy, including one in the DONE cycle, are ignored.
    mode = 0;
    issue(5'd3, 8'hFF, acc);
    for (int k = 0; k < 4; k++) begin
      while (cyc < acc + offs[k]) @(negedge clk);
      challenge = 5'd7;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
    end
    wait_idle("timeout_busy_start");
    repeat (20) @(negedge clk);
    check("no_restart_busy", {31'd0, busy}, 32'd0);
    check("no_restart_resp", {24'd0, response}, 32'h0000_00FF);

    // Reset in the COUNT phase of bit 3: bits 0..2 are already set in response.
    mode = 0;
    issue(5'd9, 8'hFF, acc);
    while (cyc < acc + 3 * BITLEN + SETTLE + 20) @(negedge clk);
    check("pre_reset_resp", {24'd0, response}, 32'h0000_0007);
    #1 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("arst_ro_en", {31'd0, ro_en}, 32'd0);
    check("arst_sel_a", {27'd0, sel_a}, 32'd0);
    check("arst_sel_b", {27'd0, sel_b}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_valid", {31'd0, valid}, 32'd0);
    check("arst_response", {24'd0, response}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(5'd5, 8'hFF, acc);
    wait_idle("timeout_after_reset");
    check_hold(8'hFF);

    // Saturation: A gives 16 edges per window (saturates at 15), B gives 8.
    // A wrapping counter would read 0 and lose every compare.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    begin
      int n;
      n = 0;
      while (!done2 && n < 4 * BITLEN + 20) begin
        @(negedge clk);
        n++;
      end
      if (!done2) fail_now("timeout_saturation");
      else begin
        check("sat_response", {28'd0, response2}, 32'h0000_000F);
        check("sat_valid", {31'd0, valid2}, 32'd1);
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
